mips_debug_step_ctrl: RTL and testbench

//  Debug-side controller directly upstream of MIPS_DLX. Owns the core's enable

---
 rtl/mips_debug_step_ctrl_if.sv | 27 ++
 rtl/mips_debug_step_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mips_debug_step_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_debug_step_ctrl_if.sv
// Signal bundle between the debug step controller, its command/frame byte streams and MIPS_DLX.
// master = controller side, slave = environment (command source, frame sink, core).
interface mips_debug_step_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       cmd_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             mips_enable;
  logic [9:0]       debug_signal;
  logic             zero;
  logic             prog_done;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  cmd_data, cmd_valid, debug_signal, zero, prog_done, tx_ready,
    output cmd_ready, mips_enable, tx_data, tx_valid, cycle_count
  );

  modport slave (
    output cmd_data, cmd_valid, debug_signal, zero, prog_done, tx_ready,
    input  cmd_ready, mips_enable, tx_data, tx_valid, cycle_count
  );
endinterface

// File: rtl/mips_debug_step_ctrl.sv
// Run / single-step / halt controller in front of MIPS_DLX; sends a 4-byte state frame after each stop.
// Optional breakpoint command ('b', hi, lo) is compiled in when DBG_BREAKPOINT_EN is defined.
module mips_debug_step_ctrl #(
  parameter int         CNT_W    = 16,
  parameter logic [7:0] CMD_RUN  = 8'h63,
  parameter logic [7:0] CMD_STEP = 8'h73,
  parameter logic [7:0] CMD_HALT = 8'h68,
  parameter logic [7:0] CMD_DUMP = 8'h64,
  parameter logic [7:0] CMD_CLR  = 8'h72
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  mips_debug_step_ctrl_if.master bus
);

`ifdef DBG_BREAKPOINT_EN
  localparam logic [7:0] CMD_BP = 8'h62;
  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_STEP, S_CAPTURE, S_SEND, S_BP_HI, S_BP_LO
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_STEP, S_CAPTURE, S_SEND
  } state_t;
`endif

  state_t           r_state;
  logic             r_enable;
  logic             r_cmd_ready;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;
  logic [1:0]       r_idx;
  logic [26:0]      r_snap;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic             w_halt;
  logic             w_bp_hit;
  logic [26:0]      w_snap;

  // Snapshot layout: {count[15:0], zero, debug[9:0]}
  function automatic logic [7:0] frame_byte(input logic [26:0] snap, input logic [1:0] idx);
    case (idx)
      2'd0:    frame_byte = snap[26:19];
      2'd1:    frame_byte = snap[18:11];
      2'd2:    frame_byte = {snap[10], 5'b0, snap[9:8]};
      default: frame_byte = snap[7:0];
    endcase
  endfunction

  assign w_accept = bus.cmd_valid & bus.cmd_ready;
  assign w_halt   = w_accept && (bus.cmd_data == CMD_HALT);
  assign w_snap   = {r_count[15:0], bus.zero, bus.debug_signal};

`ifdef DBG_BREAKPOINT_EN
  logic [9:0] r_bp;
  logic       r_bp_armed;
  assign w_bp_hit = r_bp_armed && (bus.debug_signal == r_bp);
`else
  assign w_bp_hit = 1'b0;
`endif

  // Held-off while reset is asserted so no byte is consumed in the reset cycle
  assign bus.cmd_ready   = r_cmd_ready & i_reset_n;
  assign bus.mips_enable = r_enable;
  assign bus.tx_valid    = r_tx_valid;
  assign bus.tx_data     = r_tx_data;
  assign bus.cycle_count = r_count;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_enable    <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_idx       <= '0;
      r_snap      <= '0;
      r_count     <= '0;
`ifdef DBG_BREAKPOINT_EN
      r_bp        <= '0;
      r_bp_armed  <= 1'b0;
`endif
    end else begin
      if (r_enable) r_count <= r_count + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.cmd_data == CMD_RUN) begin
              r_state  <= S_RUN;
              r_enable <= 1'b1;
            end else if (bus.cmd_data == CMD_STEP) begin
              r_state     <= S_STEP;
              r_enable    <= 1'b1;
              r_cmd_ready <= 1'b0;
            end else if (bus.cmd_data == CMD_DUMP) begin
              r_state     <= S_CAPTURE;
              r_cmd_ready <= 1'b0;
            end else if (bus.cmd_data == CMD_CLR) begin
              r_count <= '0;
`ifdef DBG_BREAKPOINT_EN
            end else if (bus.cmd_data == CMD_BP) begin
              r_state <= S_BP_HI;
`endif
            end
          end
        end

        S_RUN: begin
          if (w_halt || bus.prog_done || w_bp_hit) begin
            r_state     <= S_CAPTURE;
            r_enable    <= 1'b0;
            r_cmd_ready <= 1'b0;
          end
        end

        S_STEP: begin
          r_state  <= S_CAPTURE;
          r_enable <= 1'b0;
        end

        S_CAPTURE: begin
          r_snap     <= w_snap;
          r_tx_data  <= frame_byte(w_snap, 2'd0);
          r_tx_valid <= 1'b1;
          r_idx      <= 2'd0;
          r_state    <= S_SEND;
        end

        S_SEND: begin
          if (bus.tx_ready) begin
            if (r_idx == 2'd3) begin
              r_state     <= S_IDLE;
              r_tx_valid  <= 1'b0;
              r_cmd_ready <= 1'b1;
            end else begin
              r_idx     <= r_idx + 2'd1;
              r_tx_data <= frame_byte(r_snap, r_idx + 2'd1);
            end
          end
        end

`ifdef DBG_BREAKPOINT_EN
        S_BP_HI: begin
          if (w_accept) begin
            r_bp[9:8] <= bus.cmd_data[1:0];
            r_state   <= S_BP_LO;
          end
        end

        S_BP_LO: begin
          if (w_accept) begin
            r_bp[7:0]  <= bus.cmd_data;
            r_bp_armed <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_debug_step_ctrl.sv
// Bench for mips_debug_step_ctrl: vector table, hand-written corner sequences and a random run
// compared against a transaction-level model of the enabled-cycle count and the state frame.
module tb_mips_debug_step_ctrl;

  localparam logic [7:0] CMD_RUN  = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_HALT = 8'h68;
  localparam logic [7:0] CMD_DUMP = 8'h64;
  localparam logic [7:0] CMD_CLR  = 8'h72;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mips_debug_step_ctrl_if #(.CNT_W(16)) bus ();

  mips_debug_step_ctrl #(.CNT_W(16)) dut (
    .i_clock   (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int en_cycles = 0;
  int exp_cnt = 0;

  always @(negedge clk) if (bus.mips_enable === 1'b1) en_cycles++;

  typedef struct {
    logic [7:0]  op;
    logic [9:0]  dbg;
    logic        z;
    int          wait_n;
    logic [31:0] fr;
    int          en;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame from count, zero flag and debug word, by plain arithmetic
  function automatic logic [31:0] model_frame(input int cnt, input logic z, input int dbg);
    int c;
    c = cnt % 65536;
    return {8'(c / 256), 8'(c % 256), z, 5'b0, 2'(dbg / 256), 8'(dbg % 256)};
  endfunction

  task automatic send(input logic [7:0] b);
    bit done;
    done = 1'b0;
    bus.cmd_data  = b;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      done = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accept", 32'(done), 32'd1);
  endtask

  // mode 0: always ready, 1: ready toggles starting low, 2: random ready
  task automatic get_frame(input int mode, output logic [31:0] fr);
    int n;
    logic held, rdy;
    logic [7:0] prev;
    n = 0; held = 1'b0; prev = '0; fr = '0;
    for (int c = 0; c < 80 && n < 4; c++) begin
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = c[0];
      else rdy = 1'($urandom_range(0, 1));
      bus.tx_ready = rdy;
      if (held) begin
        chk("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
        chk("tx_hold_data", 32'(bus.tx_data), 32'(prev));
      end
      held = 1'b0;
      if (bus.tx_valid) begin
        chk("send_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        if (rdy) begin
          fr = {fr[23:0], bus.tx_data};
          n++;
        end else begin
          held = 1'b1;
          prev = bus.tx_data;
        end
      end
      tick();
    end
    bus.tx_ready = 1'b0;
    chk("frame_bytes", 32'(n), 32'd4);
  endtask

  task automatic do_op(input logic [7:0] op, input logic [9:0] dbg, input logic z,
                       input int wait_n, input int stop, input bit extra, input int mode,
                       output logic [31:0] fr, output int en_d);
    int e0, q;
    fr = '0;
    bus.debug_signal = dbg;
    bus.zero = z;
    e0 = en_cycles;
    if (op == CMD_RUN) begin
      send(CMD_RUN);
      if (extra) begin
        send(CMD_DUMP);
        repeat (wait_n - 1) tick();
      end else begin
        repeat (wait_n) tick();
      end
      if (stop == 1) begin
        bus.prog_done = 1'b1;
        tick();
        bus.prog_done = 1'b0;
      end else begin
        bus.prog_done = (stop == 2);
        send(CMD_HALT);
        bus.prog_done = 1'b0;
      end
      chk("halt_enable_low", 32'(bus.mips_enable), 32'd0);
      get_frame(mode, fr);
    end else begin
      send(op);
      if (op == CMD_STEP || op == CMD_DUMP) get_frame(mode, fr);
      else repeat (3) tick();
    end
    q = 0;
    repeat (4) begin
      tick();
      if (bus.tx_valid) q++;
    end
    chk("no_extra_frame", 32'(q), 32'd0);
    en_d = en_cycles - e0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fr, exp_fr;
    int en_d, e0, q, k, wn, st, md;
    logic [9:0] rd;
    logic rz;
    bit ex;

    tbl[0] = '{8'h72, 10'h000, 1'b0,   0, 32'h00000000,   0, 16'h0000};
    tbl[1] = '{8'h73, 10'h2A5, 1'b1,   0, 32'h000182A5,   1, 16'h0001};
    tbl[2] = '{8'h72, 10'h000, 1'b0,   0, 32'h00000000,   0, 16'h0000};
    tbl[3] = '{8'h63, 10'h3FF, 1'b0, 300, 32'h012D03FF, 301, 16'h012D};
    tbl[4] = '{8'h64, 10'h000, 1'b1,   0, 32'h012D8000,   0, 16'h012D};
    tbl[5] = '{8'h73, 10'h100, 1'b0,   0, 32'h012E0100,   1, 16'h012E};
    tbl[6] = '{8'h78, 10'h0AA, 1'b1,   0, 32'h00000000,   0, 16'h012E};
    tbl[7] = '{8'h68, 10'h155, 1'b0,   0, 32'h00000000,   0, 16'h012E};

    bus.cmd_data = '0; bus.cmd_valid = 1'b0; bus.debug_signal = '0; bus.zero = 1'b0;
    bus.prog_done = 1'b0; bus.tx_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    chk("rst_enable", 32'(bus.mips_enable), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_count", 32'(bus.cycle_count), 32'd0);
    chk("rst_cmd_ready_held", 32'(bus.cmd_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_cmd_ready_released", 32'(bus.cmd_ready), 32'd1);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].op, tbl[i].dbg, tbl[i].z, tbl[i].wait_n, 0, 1'b0, 0, fr, en_d);
      if (tbl[i].op == CMD_STEP || tbl[i].op == CMD_DUMP || tbl[i].op == CMD_RUN)
        chk($sformatf("tbl%0d_frame", i), fr, tbl[i].fr);
      chk($sformatf("tbl%0d_en", i), 32'(en_d), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_count", i), 32'(bus.cycle_count), 32'(tbl[i].cnt));
    end
    exp_cnt = 32'h12E;

    // Step latency, byte hold with toggling tx_ready, command refused during SEND
    bus.debug_signal = 10'h1E7; bus.zero = 1'b0;
    e0 = en_cycles;
    exp_cnt = (exp_cnt + 1) % 65536;
    exp_fr = model_frame(exp_cnt, 1'b0, 10'h1E7);
    send(CMD_STEP);
    chk("step_en_t1", 32'(bus.mips_enable), 32'd1);
    tick();
    chk("step_en_t2", 32'(bus.mips_enable), 32'd0);
    chk("step_txv_t2", 32'(bus.tx_valid), 32'd0);
    tick();
    chk("step_txv_t3", 32'(bus.tx_valid), 32'd1);
    chk("step_byte0_t3", 32'(bus.tx_data), 32'(exp_fr[31:24]));
    bus.cmd_data = CMD_STEP; bus.cmd_valid = 1'b1;
    chk("send_refuses_cmd", 32'(bus.cmd_ready), 32'd0);
    get_frame(1, fr);
    bus.cmd_valid = 1'b0;
    repeat (4) tick();
    chk("toggle_frame", fr, exp_fr);
    chk("toggle_en", 32'(en_cycles - e0), 32'd1);
    chk("toggle_count", 32'(bus.cycle_count), 32'(exp_cnt));

    // HALT and prog_done in the same cycle
    do_op(CMD_RUN, 10'h0C3, 1'b1, 20, 2, 1'b0, 0, fr, en_d);
    exp_cnt = (exp_cnt + 21) % 65536;
    chk("both_stop_frame", fr, model_frame(exp_cnt, 1'b1, 10'h0C3));
    chk("both_stop_en", 32'(en_d), 32'd21);

    // prog_done outside RUN is ignored
    e0 = en_cycles;
    bus.prog_done = 1'b1;
    repeat (3) tick();
    bus.prog_done = 1'b0;
    chk("done_idle_en", 32'(en_cycles - e0), 32'd0);
    chk("done_idle_txv", 32'(bus.tx_valid), 32'd0);

`ifndef DBG_BREAKPOINT_EN
    do_op(8'h62, 10'h000, 1'b0, 0, 0, 1'b0, 0, fr, en_d);
    chk("b_ignored_en", 32'(en_d), 32'd0);
    do_op(CMD_STEP, 10'h210, 1'b1, 0, 0, 1'b0, 0, fr, en_d);
    exp_cnt = (exp_cnt + 1) % 65536;
    chk("b_then_step_frame", fr, model_frame(exp_cnt, 1'b1, 10'h210));
`endif

    // Randomised operations against the model
    for (int it = 0; it < 30; it++) begin
      k  = $urandom_range(0, 5);
      wn = $urandom_range(1, 40);
      st = $urandom_range(0, 2);
      ex = 1'($urandom_range(0, 1));
      md = $urandom_range(0, 2);
      rd = 10'($urandom_range(0, 1023));
      rz = 1'($urandom_range(0, 1));
      case (k)
        0: begin
          do_op(CMD_STEP, rd, rz, 0, 0, 1'b0, md, fr, en_d);
          exp_cnt = (exp_cnt + 1) % 65536;
          chk("rnd_step_frame", fr, model_frame(exp_cnt, rz, int'(rd)));
          chk("rnd_step_en", 32'(en_d), 32'd1);
        end
        1: begin
          do_op(CMD_RUN, rd, rz, wn, st, ex, md, fr, en_d);
          exp_cnt = (exp_cnt + wn + 1) % 65536;
          chk("rnd_run_frame", fr, model_frame(exp_cnt, rz, int'(rd)));
          chk("rnd_run_en", 32'(en_d), 32'(wn + 1));
        end
        2: begin
          do_op(CMD_DUMP, rd, rz, 0, 0, 1'b0, md, fr, en_d);
          chk("rnd_dump_frame", fr, model_frame(exp_cnt, rz, int'(rd)));
          chk("rnd_dump_en", 32'(en_d), 32'd0);
        end
        3: begin
          do_op(CMD_CLR, rd, rz, 0, 0, 1'b0, md, fr, en_d);
          exp_cnt = 0;
          chk("rnd_clr_en", 32'(en_d), 32'd0);
        end
        4: begin
          do_op(CMD_HALT, rd, rz, 0, 0, 1'b0, md, fr, en_d);
          chk("rnd_halt_idle_en", 32'(en_d), 32'd0);
        end
        default: begin
          do_op(8'h00, rd, rz, 0, 0, 1'b0, md, fr, en_d);
          chk("rnd_unknown_en", 32'(en_d), 32'd0);
        end
      endcase
      chk("rnd_count", 32'(bus.cycle_count), 32'(exp_cnt));
    end

    // Reset in the middle of a frame
    bus.debug_signal = 10'h3C3; bus.zero = 1'b1;
    send(CMD_STEP);
    tick();
    tick();
    chk("pre_reset_in_send", 32'(bus.tx_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("midrst_cmd_ready_held", 32'(bus.cmd_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("midrst_enable", 32'(bus.mips_enable), 32'd0);
    chk("midrst_count", 32'(bus.cycle_count), 32'd0);
    chk("midrst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.tx_ready = 1'b1;
    q = 0;
    repeat (6) begin
      tick();
      if (bus.tx_valid) q++;
    end
    bus.tx_ready = 1'b0;
    chk("midrst_no_resume", 32'(q), 32'd0);
    exp_cnt = 0;

    // Counter reaches 0xFFFF, then one step wraps it to zero
    do_op(CMD_RUN, 10'h001, 1'b0, 65534, 0, 1'b0, 0, fr, en_d);
    exp_cnt = (exp_cnt + 65535) % 65536;
    chk("full_frame", fr, model_frame(exp_cnt, 1'b0, 10'h001));
    chk("full_count", 32'(bus.cycle_count), 32'h0000FFFF);
    do_op(CMD_STEP, 10'h002, 1'b0, 0, 0, 1'b0, 0, fr, en_d);
    exp_cnt = (exp_cnt + 1) % 65536;
    chk("wrap_frame", fr, model_frame(exp_cnt, 1'b0, 10'h002));
    chk("wrap_count", 32'(bus.cycle_count), 32'd0);

`ifdef DBG_BREAKPOINT_EN
    send(8'h62);
    send(8'h02);
    send(8'h10);
    bus.debug_signal = 10'h000; bus.zero = 1'b0;
    e0 = en_cycles;
    send(CMD_RUN);
    repeat (5) tick();
    bus.debug_signal = 10'h210;
    get_frame(0, fr);
    exp_cnt = (exp_cnt + 6) % 65536;
    chk("bp_frame", fr, model_frame(exp_cnt, 1'b0, 10'h210));
    chk("bp_en", 32'(en_cycles - e0), 32'd6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
